// File: rtl/thunderbolt_sequencer_if.sv
// Handshake bundle between the thunderbolt sequencer, the battle controller
// and the thunderbolt renderer.
interface thunderbolt_sequencer_if;
   logic       start;
   logic       done_tb_pika;
   logic       done_L_tb;
   logic       done_M_tb;
   logic       done_S_tb;
   logic       done_animate;
   logic       done_tb;
   logic       enable_draw_tb_pika;
   logic       enable_draw_L_tb;
   logic       enable_draw_M_tb;
   logic       enable_draw_S_tb;
   logic       enable_animate;
   logic       busy;
   logic       attack_done;
   logic       error;
   logic [3:0] bolt_count;

   modport master (
      input  start, done_tb_pika, done_L_tb, done_M_tb, done_S_tb, done_animate, done_tb,
      output enable_draw_tb_pika, enable_draw_L_tb, enable_draw_M_tb, enable_draw_S_tb,
             enable_animate, busy, attack_done, error, bolt_count
   );

   modport slave (
      output start, done_tb_pika, done_L_tb, done_M_tb, done_S_tb, done_animate, done_tb,
      input  enable_draw_tb_pika, enable_draw_L_tb, enable_draw_M_tb, enable_draw_S_tb,
             enable_animate, busy, attack_done, error, bolt_count
   );
endinterface

// File: rtl/thunderbolt_sequencer.sv
// Thunderbolt attack sequencer: Pikachu pose, then L/M/S bolt draws with
// animation waits, a per-draw watchdog and a one-cycle attack_done pulse.
module thunderbolt_sequencer #(
   parameter int NUM_BOLTS    = 5,
   parameter int DRAW_TIMEOUT = 131071,
   parameter int TO_W         = 17
) (
   input logic                     clock,
   input logic                     reset,
   thunderbolt_sequencer_if.master bus
);
   typedef enum logic [3:0] {
      IDLE, DRAW_PIKA, DRAW_L, WAIT_L, DRAW_M, WAIT_M, DRAW_S, WAIT_S, CHECK, FINISH
   } state_t;

   state_t          state, state_nx;
   logic [TO_W-1:0] wd;
   logic            first_cyc, in_draw, timeout, to_fire, accept;
   logic [4:0]      cnt_inc;
   logic            en_pika, en_l, en_m, en_s, en_anim, busy_r, done_r, err_r;
   logic [3:0]      bolt_r;

   assign in_draw = (state == DRAW_PIKA) || (state == DRAW_L) ||
                    (state == DRAW_M)    || (state == DRAW_S);
   assign timeout = in_draw && (wd == TO_W'(DRAW_TIMEOUT - 1));
   assign cnt_inc = {1'b0, bolt_r} + 5'd1;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // first_cyc masks a done_animate that coincides with WAIT entry
   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      to_fire  = 1'b0;
      case (state)
         IDLE:      if (bus.start) begin
                       state_nx = DRAW_PIKA;
                       accept   = 1'b1;
                    end
         DRAW_PIKA: if (bus.done_tb_pika) state_nx = DRAW_L;
         DRAW_L:    if (bus.done_L_tb)    state_nx = WAIT_L;
         WAIT_L:    if (bus.done_animate && !first_cyc) state_nx = DRAW_M;
         DRAW_M:    if (bus.done_M_tb)    state_nx = WAIT_M;
         WAIT_M:    if (bus.done_animate && !first_cyc) state_nx = DRAW_S;
         DRAW_S:    if (bus.done_S_tb)    state_nx = WAIT_S;
         WAIT_S:    if (bus.done_animate && !first_cyc) state_nx = CHECK;
         CHECK:     state_nx = ((cnt_inc == 5'(NUM_BOLTS)) || bus.done_tb) ? FINISH : DRAW_L;
         FINISH:    state_nx = IDLE;
         default:   state_nx = IDLE;
      endcase
      // a done arriving on the timeout cycle still wins
      if (timeout && (state_nx == state)) begin
         state_nx = FINISH;
         to_fire  = 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wd        <= '0;
         first_cyc <= 1'b0;
         bolt_r    <= 4'd0;
         err_r     <= 1'b0;
         en_pika   <= 1'b0;
         en_l      <= 1'b0;
         en_m      <= 1'b0;
         en_s      <= 1'b0;
         en_anim   <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         first_cyc <= (state_nx != state);
         if (state_nx != state) wd <= '0;
         else if (in_draw)      wd <= wd + TO_W'(1);
         if (accept)                                bolt_r <= 4'd0;
         else if (state == CHECK && bolt_r != 4'hF) bolt_r <= bolt_r + 4'd1;
         if (accept)       err_r <= 1'b0;
         else if (to_fire) err_r <= 1'b1;
         // outputs registered from the next state so they track the current state
         en_pika <= (state_nx == DRAW_PIKA);
         en_l    <= (state_nx == DRAW_L);
         en_m    <= (state_nx == DRAW_M);
         en_s    <= (state_nx == DRAW_S);
         en_anim <= (state_nx == WAIT_L) || (state_nx == WAIT_M) || (state_nx == WAIT_S);
         busy_r  <= (state_nx != IDLE);
         done_r  <= (state_nx == FINISH);
      end
   end

   assign bus.enable_draw_tb_pika = en_pika;
   assign bus.enable_draw_L_tb    = en_l;
   assign bus.enable_draw_M_tb    = en_m;
   assign bus.enable_draw_S_tb    = en_s;
   assign bus.enable_animate      = en_anim;
   assign bus.busy                = busy_r;
   assign bus.attack_done         = done_r;
   assign bus.error               = err_r;
   assign bus.bolt_count          = bolt_r;
endmodule

// File: tb/tb_thunderbolt_sequencer.sv
// Directed bench for thunderbolt_sequencer: nominal run, early finish,
// watchdog, async reset, spurious inputs and held start.
module tb_thunderbolt_sequencer;
   localparam int NB = 2;
   localparam int TO = 20;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   thunderbolt_sequencer_if bus();

   thunderbolt_sequencer #(.NUM_BOLTS(NB), .DRAW_TIMEOUT(TO), .TO_W(5)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int    n_vec = 0;
   int    n_err = 0;
   int    ad_cnt = 0;
   int    oh_bad = 0;
   string log_s = "";
   logic [4:0] en_now;
   logic [4:0] en_prev = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // enable-order log, one-hot monitor and attack_done pulse counter
   always @(negedge clock) begin
      en_now = {bus.enable_draw_tb_pika, bus.enable_draw_L_tb, bus.enable_draw_M_tb,
                bus.enable_draw_S_tb, bus.enable_animate};
      if (!$onehot0(en_now)) oh_bad++;
      if (en_now[4] && !en_prev[4]) log_s = {log_s, "P"};
      if (en_now[3] && !en_prev[3]) log_s = {log_s, "L"};
      if (en_now[2] && !en_prev[2]) log_s = {log_s, "M"};
      if (en_now[1] && !en_prev[1]) log_s = {log_s, "S"};
      if (en_now[0] && !en_prev[0]) log_s = {log_s, "A"};
      if (bus.attack_done) ad_cnt++;
      en_prev = en_now;
   end

   function automatic logic sig(input int sel);
      case (sel)
         0:       return bus.enable_draw_tb_pika;
         1:       return bus.enable_draw_L_tb;
         2:       return bus.enable_draw_M_tb;
         3:       return bus.enable_draw_S_tb;
         4:       return bus.enable_animate;
         5:       return bus.attack_done;
         default: return bus.busy;
      endcase
   endfunction

   task automatic set_in(input int sel, input logic v);
      case (sel)
         0:       bus.done_tb_pika = v;
         1:       bus.done_L_tb    = v;
         2:       bus.done_M_tb    = v;
         3:       bus.done_S_tb    = v;
         default: bus.done_animate = v;
      endcase
   endtask

   // returns on a negedge where the selected output is high (bounded)
   task automatic wait_for(input int sel, input string tag);
      int n = 0;
      @(negedge clock);
      while (!sig(sel) && n < 200) begin
         @(negedge clock);
         n++;
      end
      chk(tag, sig(sel), 1'b1);
   endtask

   task automatic draw_step(input int sel, input int dly);
      wait_for(sel, $sformatf("wait_en%0d", sel));
      repeat (dly - 1) @(posedge clock);
      #1 set_in(sel, 1'b1);
      @(posedge clock);
      #1 set_in(sel, 1'b0);
   endtask

   task automatic run_bolts(input int n);
      for (int b = 0; b < n; b++) begin
         draw_step(1, 3); draw_step(4, 4);
         draw_step(2, 3); draw_step(4, 4);
         draw_step(3, 3); draw_step(4, 4);
      end
   endtask

   task automatic start_pulse();
      @(posedge clock);
      #1 bus.start = 1'b1;
      @(posedge clock);
      #1 bus.start = 1'b0;
   endtask

   task automatic chk_order(input string tag, input int base, input string exp);
      chk({tag, "_len"}, log_s.len() - base, exp.len());
      for (int i = 0; i < exp.len() && base + i < log_s.len(); i++)
         chk($sformatf("%s_%0d", tag, i), log_s[base + i], exp[i]);
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_en"}, {27'd0, bus.enable_draw_tb_pika, bus.enable_draw_L_tb,
                         bus.enable_draw_M_tb, bus.enable_draw_S_tb, bus.enable_animate}, 0);
      chk({tag, "_busy"}, bus.busy, 1'b0);
      chk({tag, "_ad"}, bus.attack_done, 1'b0);
      chk({tag, "_cnt"}, bus.bolt_count, 4'd0);
   endtask

   initial begin
      int a0, b0, o0, n;
      bus.start = 1'b0; bus.done_tb_pika = 1'b0; bus.done_L_tb = 1'b0;
      bus.done_M_tb = 1'b0; bus.done_S_tb = 1'b0; bus.done_animate = 1'b0;
      bus.done_tb = 1'b0;

      // reset state
      repeat (2) @(posedge clock);
      #1 chk_quiet("rst");
      chk("rst_err", bus.error, 1'b0);
      reset = 1'b0;

      // nominal, two bolt cycles
      a0 = ad_cnt; b0 = log_s.len(); o0 = oh_bad;
      start_pulse();
      draw_step(0, 3);
      run_bolts(1);
      wait_for(1, "nom_l2");
      chk("nom_cnt_mid", bus.bolt_count, 4'd1);
      run_bolts(1);
      wait_for(5, "nom_ad");
      chk("nom_cnt", bus.bolt_count, 4'd2);
      chk("nom_err", bus.error, 1'b0);
      repeat (3) @(negedge clock);
      chk("nom_busy", bus.busy, 1'b0);
      chk("nom_ad_cnt", ad_cnt - a0, 1);
      chk_order("nom_order", b0, "PLAMASALAMASA");
      chk("nom_onehot", oh_bad - o0, 0);

      // early finish via done_tb, plus spurious done_S and early done_animate
      a0 = ad_cnt; b0 = log_s.len();
      bus.done_tb = 1'b1;
      start_pulse();
      draw_step(0, 3);
      wait_for(1, "ef_l");
      bus.done_S_tb = 1'b1;
      repeat (5) @(negedge clock);
      chk("spur_L_hold", bus.enable_draw_L_tb, 1'b1);
      chk("spur_no_wait", bus.enable_animate, 1'b0);
      draw_step(1, 3);
      bus.done_S_tb = 1'b0;
      bus.done_animate = 1'b1;
      @(posedge clock);
      #1 bus.done_animate = 1'b0;
      @(negedge clock);
      chk("anim_early_hold", bus.enable_animate, 1'b1);
      chk("anim_early_noM", bus.enable_draw_M_tb, 1'b0);
      draw_step(4, 4);
      draw_step(2, 3); draw_step(4, 4);
      draw_step(3, 3); draw_step(4, 4);
      wait_for(5, "ef_ad");
      chk("ef_cnt", bus.bolt_count, 4'd1);
      repeat (4) @(negedge clock);
      chk("ef_ad_cnt", ad_cnt - a0, 1);
      chk("ef_busy", bus.busy, 1'b0);
      chk_order("ef_order", b0, "PLAMASA");
      bus.done_tb = 1'b0;

      // watchdog on a stuck medium draw
      a0 = ad_cnt;
      start_pulse();
      draw_step(0, 3); draw_step(1, 3); draw_step(4, 4);
      wait_for(2, "wd_m");
      n = 0;
      while (bus.enable_draw_M_tb && n < 100) begin
         n++;
         @(negedge clock);
      end
      chk("wd_len", n, TO);
      chk("wd_err", bus.error, 1'b1);
      chk("wd_ad", bus.attack_done, 1'b1);
      @(negedge clock);
      chk("wd_idle", bus.busy, 1'b0);
      chk("wd_sticky", bus.error, 1'b1);
      chk("wd_ad_cnt", ad_cnt - a0, 1);
      start_pulse();
      @(negedge clock);
      chk("wd_clr", bus.error, 1'b0);
      chk("wd_restart", bus.enable_draw_tb_pika, 1'b1);

      // async reset in WAIT_M, between edges
      a0 = ad_cnt;
      draw_step(0, 3); draw_step(1, 3); draw_step(4, 4); draw_step(2, 3);
      wait_for(4, "ar_wm");
      #2 reset = 1'b1;
      #1 chk_quiet("ar");
      @(posedge clock);
      #1 reset = 1'b0;
      repeat (3) @(negedge clock);
      chk("ar_idle", bus.busy, 1'b0);
      chk("ar_no_ad", ad_cnt - a0, 0);

      // start held across FINISH relaunches after one IDLE cycle
      a0 = ad_cnt;
      @(posedge clock);
      #1 bus.start = 1'b1;
      draw_step(0, 3);
      run_bolts(2);
      wait_for(5, "hs_ad");
      chk("hs_cnt", bus.bolt_count, 4'd2);
      @(negedge clock);
      chk("hs_idle", bus.busy, 1'b0);
      chk("hs_idle_pika", bus.enable_draw_tb_pika, 1'b0);
      @(negedge clock);
      chk("hs_pika", bus.enable_draw_tb_pika, 1'b1);
      chk("hs_cnt0", bus.bolt_count, 4'd0);
      chk("hs_ad_cnt", ad_cnt - a0, 1);
      bus.start = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
